// File: rtl/neuron_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neuron_rx_pkg                                                        |
// | Shared types and constants for the neuron output receiver.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package neuron_rx_pkg;

   localparam logic [7:0] c_HDR_MAGIC = 8'hA5;

   typedef logic signed [31:0] fix16_t;

   typedef struct packed {
      logic [31:0] hdr;
      fix16_t      v;
      fix16_t      g;
   } frame_t;

   typedef logic [1:0] rx_state_t;
   localparam rx_state_t c_ST_IDLE = 2'd0;
   localparam rx_state_t c_ST_HDR  = 2'd1;
   localparam rx_state_t c_ST_V1   = 2'd2;
   localparam rx_state_t c_ST_GM   = 2'd3;

   function automatic logic [15:0] sat_inc16(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_out_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neuron_out_rx_if                                                     |
// | Valid/ready word stream from the receiver to the host consumer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface neuron_out_rx_if;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;

   modport master (output m_data, m_valid, m_last, input  m_ready);
   modport slave  (input  m_data, m_valid, m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/sync_frame_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_frame_fifo                                                      |
// | DEPTH x 96-bit frame FIFO; a pop frees its slot for a same-cycle push.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_frame_fifo
   import neuron_rx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  frame_t din,
   input  logic   pop,
   output frame_t dout,
   output logic   full,
   output logic   empty,
   output logic   single
);
   localparam int c_AW = $clog2(DEPTH);

   frame_t            r_mem [DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_AW:0]     r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign full      = (r_count == (c_AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign single    = (r_count == (c_AW+1)'(1));
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign dout      = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/neuron_out_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neuron_out_rx                                                        |
// | Samples neuron v1/Gm, detects spikes, streams 3-word frames to host. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module neuron_out_rx
   import neuron_rx_pkg::*;
#(
   parameter int                 FRAME_LEN = 13,
   parameter int                 PHASE     = 12,
   parameter int                 DECIM     = 1,
   parameter logic signed [31:0] DROP_TH   = 32'sh0028_0000,
   parameter int                 DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [15:0]            iv1i,
   input  logic [15:0]            iv1d,
   input  logic [15:0]            iGmi,
   input  logic [15:0]            iGmd,
   neuron_out_rx_if.master        m,
   output logic                   spike,
   output logic [15:0]            spike_cnt,
   output logic [15:0]            drop_cnt
);
   localparam int c_PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   logic [c_PW-1:0]    r_phase;
   logic [7:0]         r_decim;
   logic               w_sample;
   logic               w_keep;
   fix16_t             r_v, r_g, r_prev;
   logic               r_prev_ok;
   logic               r_pend;
   logic [15:0]        r_isi;
   logic [6:0]         r_seq;
   logic               r_spike;
   logic [15:0]        r_spike_cnt;
   logic [15:0]        r_drop_cnt;
   logic signed [32:0] w_diff;
   logic signed [32:0] w_th;
   logic               w_spike;
   logic [15:0]        w_isi_inc;
   frame_t             w_frame;
   frame_t             w_head;
   logic               w_full, w_empty, w_single;
   logic               w_fire, w_pop;
   rx_state_t          r_state;

   assign w_sample = (r_phase == c_PW'(PHASE));
   assign w_keep   = w_sample && (r_decim == 8'd0);

   // Spike test uses the sample captured one cycle earlier, in 33 bits so the drop cannot wrap.
   assign w_diff    = {r_prev[31], r_prev} - {r_v[31], r_v};
   assign w_th      = {DROP_TH[31], DROP_TH};
   assign w_spike   = r_pend && r_prev_ok && (w_diff > w_th);
   assign w_isi_inc = sat_inc16(r_isi);

   always_comb begin
      w_frame     = '0;
      w_frame.hdr = {c_HDR_MAGIC, w_spike, r_seq, w_isi_inc};
      w_frame.v   = r_v;
      w_frame.g   = r_g;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= '0;
         r_decim <= '0;
         r_v     <= '0;
         r_g     <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_phase <= (r_phase == c_PW'(FRAME_LEN-1)) ? '0 : r_phase + 1'b1;
         if (w_sample)
            r_decim <= (r_decim == 8'(DECIM-1)) ? 8'd0 : r_decim + 8'd1;
         if (w_keep) begin
            r_v <= {iv1i, iv1d};
            r_g <= {iGmi, iGmd};
         end
         r_pend <= w_keep;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev      <= '0;
         r_prev_ok   <= 1'b0;
         r_isi       <= '0;
         r_seq       <= '0;
         r_spike     <= 1'b0;
         r_spike_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_spike <= w_spike;
         if (r_pend) begin
            r_prev    <= r_v;
            r_prev_ok <= 1'b1;
            r_isi     <= w_spike ? 16'd0 : w_isi_inc;
            r_seq     <= r_seq + 7'd1;
            if (w_spike) r_spike_cnt <= sat_inc16(r_spike_cnt);
            if (w_full && !w_pop) r_drop_cnt <= sat_inc16(r_drop_cnt);
         end
      end
   end

   sync_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (r_pend),
      .din    (w_frame),
      .pop    (w_pop),
      .dout   (w_head),
      .full   (w_full),
      .empty  (w_empty),
      .single (w_single)
   );

   // The frame stays at the FIFO head until its last word leaves, keeping words stable under stall.
   assign w_fire = m.m_valid && m.m_ready;
   assign w_pop  = w_fire && (r_state == c_ST_GM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         case (r_state)
            c_ST_IDLE: if (!w_empty) r_state <= c_ST_HDR;
            c_ST_HDR:  if (w_fire)   r_state <= c_ST_V1;
            c_ST_V1:   if (w_fire)   r_state <= c_ST_GM;
            c_ST_GM:   if (w_fire)   r_state <= (!w_single || r_pend) ? c_ST_HDR : c_ST_IDLE;
            default:                 r_state <= c_ST_IDLE;
         endcase
      end
   end

   always_comb begin
      m.m_data = '0;
      case (r_state)
         c_ST_HDR: m.m_data = w_head.hdr;
         c_ST_V1:  m.m_data = w_head.v;
         c_ST_GM:  m.m_data = w_head.g;
         default:  m.m_data = '0;
      endcase
   end

   assign m.m_valid = (r_state != c_ST_IDLE);
   assign m.m_last  = (r_state == c_ST_GM);
   assign spike     = r_spike;
   assign spike_cnt = r_spike_cnt;
   assign drop_cnt  = r_drop_cnt;
endmodule
`default_nettype wire
